// File: rtl/line_cache_sdram_writer_if.sv
// Bus bundle between the line-cache writer (master), the line-cache read port and the
// SDRAM controller write port (slave side).
interface line_cache_sdram_writer_if #(
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int DATA_W = 16
);
  logic [10:0]            cache_rd_address;
  logic [DATA_W-1:0]      cache_rd_data;
  logic                   sd_req;
  logic [ROW_W+COL_W-1:0] sd_addr;
  logic                   sd_gnt;
  logic [DATA_W-1:0]      sd_wdata;
  logic                   sd_wdata_next;

  modport master (
    output cache_rd_address, sd_req, sd_addr, sd_wdata,
    input  cache_rd_data, sd_gnt, sd_wdata_next
  );

  modport slave (
    input  cache_rd_address, sd_req, sd_addr, sd_wdata,
    output cache_rd_data, sd_gnt, sd_wdata_next
  );
endinterface

// File: rtl/line_cache_sdram_writer.sv
// Copies a finished line-cache row into SDRAM as fixed-length write bursts, then toggles s_ack.
// Optional WRITER_OVERRUN_DETECT_EN adds sticky overrun and saturating overrun_cnt outputs.
module line_cache_sdram_writer #(
  parameter int ROW_WORDS = 752,
  parameter int BURST_LEN = 8,
  parameter int COL_W     = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             s_req,
  output logic                             s_ack,
  input  logic                             s_cache_row,
  input  logic [9:0]                       s_sdram_row,
  line_cache_sdram_writer_if.master        bus,
  output logic                             busy
`ifdef WRITER_OVERRUN_DETECT_EN
  ,
  output logic                             overrun,
  output logic [7:0]                       overrun_cnt
`endif
);
  localparam int PTR_W  = 10;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PTR_W-1:0]  ROW_END   = PTR_W'(ROW_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    REQ      = 3'd2,
    DATA     = 3'd3,
    ACK      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                req_meta_q, req_sync_q;
  logic                s_ack_q, s_ack_d;
  logic                busy_q, busy_d;
  logic                sd_req_q, sd_req_d;
  logic                half_q, half_d;
  logic [9:0]          row_q, row_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    ptr_inc_s, rd_col_s;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                pending_s;

  assign pending_s = req_sync_q ^ s_ack_q;

  // Two-flop synchronizer for the asynchronous request toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= s_req;
      req_sync_q <= req_meta_q;
    end
  end

  // Transfer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      s_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      sd_req_q <= 1'b0;
      half_q   <= 1'b0;
      row_q    <= 10'd0;
      ptr_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      s_ack_q  <= s_ack_d;
      busy_q   <= busy_d;
      sd_req_q <= sd_req_d;
      half_q   <= half_d;
      row_q    <= row_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic; the read address runs one word ahead on every consumed beat
  always_comb begin
    state_d   = state_q;
    s_ack_d   = s_ack_q;
    busy_d    = busy_q;
    sd_req_d  = 1'b0;
    half_d    = half_q;
    row_d     = row_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    ptr_inc_s = ptr_q + PTR_W'(1);
    rd_col_s  = ptr_q;
    case (state_q)
      IDLE: begin
        if (pending_s) begin
          row_d   = s_sdram_row;
          half_d  = s_cache_row;
          ptr_d   = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
          state_d = PREFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      PREFETCH: begin
        state_d = REQ;
      end
      REQ: begin
        if (bus.sd_gnt) begin
          state_d = DATA;
        end else begin
          state_d = REQ;
        end
      end
      DATA: begin
        if (bus.sd_wdata_next) begin
          rd_col_s = ptr_inc_s;
          ptr_d    = ptr_inc_s;
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            // s_ack flips on the edge right after the final word so the sampler sees it one cycle later
            if (ptr_inc_s == ROW_END) begin
              state_d = ACK;
              s_ack_d = ~s_ack_q;
              busy_d  = 1'b0;
            end else begin
              state_d = REQ;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    sd_req_d = (state_d == REQ);
  end

  assign s_ack                = s_ack_q;
  assign busy                 = busy_q;
  assign bus.sd_req           = sd_req_q;
  assign bus.sd_addr          = {row_q, ptr_q[COL_W-1:0]};
  assign bus.sd_wdata         = bus.cache_rd_data;
  assign bus.cache_rd_address = {half_q, rd_col_s};

`ifdef WRITER_OVERRUN_DETECT_EN
  logic       req_prev_q;
  logic       overrun_q, overrun_d;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  // A request toggle seen while busy means the sampler lapped this writer
  always_comb begin
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    if (busy_q && (req_sync_q != req_prev_q)) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != 8'hFF) begin
        overrun_cnt_d = overrun_cnt_q + 8'd1;
      end else begin
        overrun_cnt_d = overrun_cnt_q;
      end
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_prev_q    <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 8'd0;
    end else begin
      req_prev_q    <= req_sync_q;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
`endif
endmodule

// File: tb/tb_line_cache_sdram_writer.sv
// Scoreboard bench: expected burst addresses, words and ack values are queued when a row
// request is issued and checked as the controller model consumes the DUT's bursts.
module tb_line_cache_sdram_writer;
  localparam int ROW_WORDS  = 752;
  localparam int BURST_LEN  = 8;
  localparam int GNT_DELAY  = 3;
  localparam int WAIT_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_req;
  logic        s_ack;
  logic        s_cache_row;
  logic [9:0]  s_sdram_row;
  logic        busy;
  logic        ctl_gnt, ctl_next, spur_gnt, spur_next;
  logic        data_phase;
  int          gap;
  int          row_word_cnt;
  int          rows_done;
  int          n_checks;
  int          n_fail;
  logic [19:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic        exp_ack_q[$];
  logic [15:0] mem [0:2047];
`ifdef WRITER_OVERRUN_DETECT_EN
  logic        overrun;
  logic [7:0]  overrun_cnt;
`endif

  line_cache_sdram_writer_if bus_if ();

  assign bus_if.sd_gnt        = ctl_gnt | spur_gnt;
  assign bus_if.sd_wdata_next = ctl_next | spur_next;

  line_cache_sdram_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_req       (s_req),
    .s_ack       (s_ack),
    .s_cache_row (s_cache_row),
    .s_sdram_row (s_sdram_row),
    .bus         (bus_if),
    .busy        (busy)
`ifdef WRITER_OVERRUN_DETECT_EN
    ,
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Line cache second port: registered read, one cycle latency
  always @(posedge clk) bus_if.cache_rd_data <= mem[bus_if.cache_rd_address];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input logic half, input logic [9:0] row, input logic ack);
    for (int b = 0; b < ROW_WORDS / BURST_LEN; b++)
      exp_addr_q.push_back({row, 10'(b * BURST_LEN)});
    for (int n = 0; n < ROW_WORDS; n++)
      exp_data_q.push_back(mem[{half, 10'(n)}]);
    exp_ack_q.push_back(ack);
  endtask

  task automatic wait_rows(input int target, input string tag);
    int guard;
    guard = 0;
    while (rows_done < target && guard < WAIT_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    check_val(tag, 32'(rows_done), 32'(target));
  endtask

  task automatic abort_on_reset();
    ctl_gnt      = 1'b0;
    ctl_next     = 1'b0;
    data_phase   = 1'b0;
    row_word_cnt = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_ack_q.delete();
  endtask

  // SDRAM controller model: grant after GNT_DELAY cycles, then consume BURST_LEN words
  task automatic serve_burst();
    logic [19:0] a_exp;
    logic [15:0] d_exp;
    logic        k_exp;
    logic        more_rows;
    if (exp_addr_q.size() == 0) begin
      check_val("unexpected_sd_req", 32'd1, 32'd0);
      return;
    end
    a_exp = exp_addr_q.pop_front();
    check_val("sd_addr", 32'(bus_if.sd_addr), 32'(a_exp));
    for (int w = 0; w < GNT_DELAY; w++) begin
      @(negedge clk);
      if (!reset_n) begin abort_on_reset(); return; end
      check_val("sd_req_hold", 32'(bus_if.sd_req), 32'd1);
      check_val("sd_addr_hold", 32'(bus_if.sd_addr), 32'(a_exp));
    end
    ctl_gnt = 1'b1;
    @(negedge clk);
    ctl_gnt = 1'b0;
    if (!reset_n) begin abort_on_reset(); return; end
    data_phase = 1'b1;
    for (int b = 0; b < BURST_LEN; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (!reset_n) begin abort_on_reset(); return; end
      end
      check_val("sd_req_in_data", 32'(bus_if.sd_req), 32'd0);
      if (exp_data_q.size() == 0) begin
        check_val("data_queue_empty", 32'd1, 32'd0);
        d_exp = 16'h0000;
      end else begin
        d_exp = exp_data_q.pop_front();
      end
      check_val("sd_wdata", 32'(bus_if.sd_wdata), 32'(d_exp));
      ctl_next = 1'b1;
      @(negedge clk);
      ctl_next = 1'b0;
      if (!reset_n) begin abort_on_reset(); return; end
      row_word_cnt++;
      if (row_word_cnt == ROW_WORDS) begin
        k_exp = exp_ack_q.size() != 0 ? exp_ack_q.pop_front() : ~s_ack;
        check_val("s_ack_after_last", 32'(s_ack), 32'(k_exp));
        check_val("busy_after_last", 32'(busy), 32'd0);
        more_rows    = exp_ack_q.size() != 0;
        row_word_cnt = 0;
        data_phase   = 1'b0;
        rows_done++;
        if (more_rows) begin
          repeat (2) @(negedge clk);
          check_val("b2b_restart_busy", 32'(busy), 32'd1);
        end
        return;
      end
    end
    data_phase = 1'b0;
  endtask

  initial begin
    ctl_gnt      = 1'b0;
    ctl_next     = 1'b0;
    data_phase   = 1'b0;
    row_word_cnt = 0;
    rows_done    = 0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus_if.sd_req === 1'b1) serve_burst();
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 2048; i++) mem[i] = 16'((i * 40503) ^ (i >> 4) ^ 16'h3C5A);
    n_checks    = 0;
    n_fail      = 0;
    gap         = 0;
    reset_n     = 1'b0;
    s_req       = 1'b0;
    s_cache_row = 1'b0;
    s_sdram_row = 10'd0;
    spur_gnt    = 1'b0;
    spur_next   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_s_ack", 32'(s_ack), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sd_req", 32'(bus_if.sd_req), 32'd0);
    check_val("rst_col", 32'(bus_if.cache_rd_address[9:0]), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spurious grant / data-next pulses while idle
    spur_gnt  = 1'b1;
    spur_next = 1'b1;
    @(negedge clk);
    spur_gnt  = 1'b0;
    spur_next = 1'b0;
    @(negedge clk);
    check_val("spur_busy", 32'(busy), 32'd0);
    check_val("spur_sd_req", 32'(bus_if.sd_req), 32'd0);
    check_val("spur_col", 32'(bus_if.cache_rd_address[9:0]), 32'd0);
    check_val("spur_s_ack", 32'(s_ack), 32'd0);

    // Single row, back-to-back data pulses
    gap = 0;
    push_row(1'b1, 10'h155, 1'b1);
    s_cache_row = 1'b1;
    s_sdram_row = 10'h155;
    s_req       = 1'b1;
    wait_rows(1, "row1_done");

    // Throttled data with row info changed after detection
    gap = 2;
    push_row(1'b0, 10'h0A3, 1'b0);
    s_cache_row = 1'b0;
    s_sdram_row = 10'h0A3;
    s_req       = 1'b0;
    guard = 0;
    while (busy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    check_val("row2_start_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    s_sdram_row = 10'h3FF;
    s_cache_row = 1'b1;
    wait_rows(2, "row2_done");

    // Second request toggled while the first is still streaming
    gap = 0;
    push_row(1'b1, 10'h011, 1'b1);
    s_cache_row = 1'b1;
    s_sdram_row = 10'h011;
    s_req       = 1'b1;
    guard = 0;
    while (row_word_cnt < 100 && guard < WAIT_LIMIT) begin @(negedge clk); guard++; end
    check_val("row3_midway_busy", 32'(busy), 32'd1);
    push_row(1'b0, 10'h222, 1'b0);
    s_cache_row = 1'b0;
    s_sdram_row = 10'h222;
    s_req       = 1'b0;
    wait_rows(4, "b2b_done");
    check_val("b2b_final_s_ack", 32'(s_ack), 32'd0);
`ifdef WRITER_OVERRUN_DETECT_EN
    check_val("overrun_flag", 32'(overrun), 32'd1);
    check_val("overrun_count", 32'(overrun_cnt), 32'd1);
`endif

    // Reset while streaming the burst at column 200
    gap = 3;
    push_row(1'b0, 10'h100, 1'b1);
    s_cache_row = 1'b0;
    s_sdram_row = 10'h100;
    s_req       = 1'b1;
    guard = 0;
    while (!(row_word_cnt == 200 && data_phase) && guard < WAIT_LIMIT) begin @(posedge clk); guard++; end
    check_val("mrst_reached_col200", 32'(row_word_cnt), 32'd200);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mrst_sd_req", 32'(bus_if.sd_req), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_s_ack", 32'(s_ack), 32'd0);
`ifdef WRITER_OVERRUN_DETECT_EN
    check_val("mrst_overrun", 32'(overrun), 32'd0);
`endif
    repeat (3) @(negedge clk);
    gap = 0;
    push_row(1'b0, 10'h100, 1'b1);
    reset_n = 1'b1;
    wait_rows(5, "post_reset_done");
    check_val("post_reset_s_ack", 32'(s_ack), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
